// File: rtl/banked_register_file.sv
// Banked CPU register file: r0-r7 are banked per interrupt level, r8-rB and
// rC (ISR) are shared, rD-rF return the external SP/SR/PC inputs.
// Reads are combinational and forward a same-cycle write.
module banked_register_file #(
  parameter int WIDTH          = 16,
  parameter int NUM_BANKS      = 4,
  parameter int NUM_READ       = 3,
  parameter int CLEAR_ON_ENTER = 0,
  localparam int PW            = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_READ*4-1:0]     read_addr,
  output logic [NUM_READ*WIDTH-1:0] read_data,
  input  logic [3:0]                write_addr,
  input  logic [WIDTH-1:0]          write_data,
  input  logic                      write_en,
  input  logic                      irq_enter,
  input  logic                      irq_exit,
  input  logic [WIDTH-1:0]          SP,
  input  logic [WIDTH-1:0]          SR,
  input  logic [WIDTH-1:0]          PC,
  output logic [PW-1:0]             bank_ptr,
  output logic                      bank_overflow,
  output logic                      bank_underflow
);

  localparam logic [PW-1:0] PTR_MAX = PW'(NUM_BANKS - 1);

  logic [WIDTH-1:0] bank_q    [NUM_BANKS][8];
  logic [WIDTH-1:0] scratch_q [4];
  logic [WIDTH-1:0] isr_q;
  logic [PW-1:0]    ptr_q;
  logic             ovf_q;
  logic             unf_q;

  logic          push_req;
  logic          pop_req;
  logic          push_ok;
  logic          pop_ok;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;

  // Simultaneous enter and exit cancel out: neither move nor flag.
  assign push_req = irq_enter & ~irq_exit;
  assign pop_req  = irq_exit & ~irq_enter;
  assign push_ok  = push_req && (ptr_q != PTR_MAX);
  assign pop_ok   = pop_req && (ptr_q != '0);
  assign ptr_inc  = ptr_q + PW'(1);
  assign ptr_dec  = ptr_q - PW'(1);

  assign bank_ptr       = ptr_q;
  assign bank_overflow  = ovf_q;
  assign bank_underflow = unf_q;

  for (genvar g = 0; g < NUM_READ; g++) begin : g_read
    logic [3:0]       addr;
    logic [WIDTH-1:0] rdata;

    assign addr = read_addr[4*g +: 4];

    // Per-port decode; a pending write to a storage register (0-C) is forwarded.
    always_comb begin
      rdata = '0;
      if (write_en && (write_addr == addr) && (write_addr <= 4'hC)) begin
        rdata = write_data;
      end else if (!addr[3]) begin
        rdata = bank_q[ptr_q][addr[2:0]];
      end else if (addr[3:2] == 2'b10) begin
        rdata = scratch_q[addr[1:0]];
      end else begin
        case (addr[1:0])
          2'd0:    rdata = isr_q;
          2'd1:    rdata = SP;
          2'd2:    rdata = SR;
          default: rdata = PC;
        endcase
      end
    end

    assign read_data[WIDTH*g +: WIDTH] = rdata;
  end

  // Register storage, bank pointer and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int r = 0; r < 8; r++) begin
          bank_q[b][r] <= '0;
        end
      end
      for (int s = 0; s < 4; s++) begin
        scratch_q[s] <= '0;
      end
      isr_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      // The cleared bank is the new one, so it never collides with a
      // same-cycle write, which still targets the old bank.
      if ((CLEAR_ON_ENTER != 0) && push_ok) begin
        for (int r = 0; r < 8; r++) begin
          bank_q[ptr_inc][r] <= '0;
        end
      end
      if (write_en) begin
        if (!write_addr[3]) begin
          bank_q[ptr_q][write_addr[2:0]] <= write_data;
        end else if (write_addr[3:2] == 2'b10) begin
          scratch_q[write_addr[1:0]] <= write_data;
        end else if (write_addr == 4'hC) begin
          isr_q <= write_data;
        end
      end
      if (push_ok) begin
        ptr_q <= ptr_inc;
      end else if (pop_ok) begin
        ptr_q <= ptr_dec;
      end
      if (push_req && !push_ok) begin
        ovf_q <= 1'b1;
      end
      if (pop_req && !pop_ok) begin
        unf_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file: a vector table for the address map
// and forwarding, plus hand-written multi-cycle sequences for banking, stack
// limits, clear-on-enter and reset priority. Two instances share the inputs:
// dut0 keeps banks on entry, dut1 clears the entered bank.
module tb_banked_register_file;

  localparam int W  = 16;
  localparam int NB = 4;
  localparam int NR = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [NR*4-1:0] read_addr;
  logic [3:0]    write_addr;
  logic [W-1:0]  write_data;
  logic          write_en;
  logic          irq_enter;
  logic          irq_exit;
  logic [W-1:0]  sp, sr, pc;
  logic [NR*W-1:0] rd0, rd1;
  logic [1:0]    bp0, bp1;
  logic          ovf0, ovf1, unf0, unf1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  banked_register_file #(.WIDTH(W), .NUM_BANKS(NB), .NUM_READ(NR), .CLEAR_ON_ENTER(0)) dut0 (
    .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(rd0),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .irq_enter(irq_enter), .irq_exit(irq_exit), .SP(sp), .SR(sr), .PC(pc),
    .bank_ptr(bp0), .bank_overflow(ovf0), .bank_underflow(unf0)
  );

  banked_register_file #(.WIDTH(W), .NUM_BANKS(NB), .NUM_READ(NR), .CLEAR_ON_ENTER(1)) dut1 (
    .clock(clock), .reset(reset), .read_addr(read_addr), .read_data(rd1),
    .write_addr(write_addr), .write_data(write_data), .write_en(write_en),
    .irq_enter(irq_enter), .irq_exit(irq_exit), .SP(sp), .SR(sr), .PC(pc),
    .bank_ptr(bp1), .bank_overflow(ovf1), .bank_underflow(unf1)
  );

  typedef struct {
    logic         we;
    logic [3:0]   wa;
    logic [W-1:0] wd;
    logic [3:0]   ra;
    logic [W-1:0] pc;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pd(input logic [NR*W-1:0] v, input int i);
    return v[W*i +: W];
  endfunction

  task automatic set_ra(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    read_addr = {a2, a1, a0};
  endtask

  // One clock edge, then drop the single-cycle strobes.
  task automatic cyc();
    @(posedge clock);
    #1;
    write_en  = 1'b0;
    irq_enter = 1'b0;
    irq_exit  = 1'b0;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [W-1:0] wd,
                              input logic [3:0] ra, input logic [W-1:0] pcv, input logic [W-1:0] exp);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.pc = pcv; v.exp = exp;
    return v;
  endfunction

  logic [1:0] up_bp [4];
  logic [1:0] dn_bp [4];

  initial begin
    // Post-reset map: storage reads zero, D-F return the inputs.
    for (int a = 0; a <= 12; a++) tbl.push_back(mk(1'b0, 4'h0, 16'h0, 4'(a), 16'h3333, 16'h0000));
    tbl.push_back(mk(1'b0, 4'h0, 16'h0, 4'hD, 16'h3333, 16'h1111));
    tbl.push_back(mk(1'b0, 4'h0, 16'h0, 4'hE, 16'h3333, 16'h2222));
    tbl.push_back(mk(1'b0, 4'h0, 16'h0, 4'hF, 16'h3333, 16'h3333));
    // Forwarding, persistence, read-only D-F, ISR, bank and scratch writes.
    tbl.push_back(mk(1'b1, 4'h9, 16'h5A5A, 4'h9, 16'h0042, 16'h5A5A));
    tbl.push_back(mk(1'b0, 4'h0, 16'h0000, 4'h9, 16'h0042, 16'h5A5A));
    tbl.push_back(mk(1'b1, 4'hF, 16'hFFFF, 4'hF, 16'h0042, 16'h0042));
    tbl.push_back(mk(1'b0, 4'h0, 16'h0000, 4'hF, 16'h0042, 16'h0042));
    tbl.push_back(mk(1'b1, 4'hC, 16'hBEEF, 4'hC, 16'h0042, 16'hBEEF));
    tbl.push_back(mk(1'b1, 4'h0, 16'h0101, 4'h1, 16'h0042, 16'h0000));
    tbl.push_back(mk(1'b0, 4'h0, 16'h0000, 4'h0, 16'h0042, 16'h0101));
    tbl.push_back(mk(1'b1, 4'hB, 16'h00BB, 4'hA, 16'h0042, 16'h0000));
    tbl.push_back(mk(1'b0, 4'h0, 16'h0000, 4'hB, 16'h0042, 16'h00BB));
    tbl.push_back(mk(1'b0, 4'h0, 16'h0000, 4'hC, 16'h0042, 16'hBEEF));

    up_bp = '{2'd1, 2'd2, 2'd3, 2'd3};
    dn_bp = '{2'd2, 2'd1, 2'd0, 2'd0};

    reset = 1'b1; write_en = 1'b0; irq_enter = 1'b0; irq_exit = 1'b0;
    write_addr = 4'h0; write_data = '0; read_addr = '0;
    sp = 16'h1111; sr = 16'h2222; pc = 16'h3333;
    cyc(); cyc();
    reset = 1'b0;
    settle();
    chk("reset_bank_ptr", {14'b0, bp0}, 16'd0);
    chk("reset_overflow", {15'b0, ovf0}, 16'd0);
    chk("reset_underflow", {15'b0, unf0}, 16'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      write_en   = tbl[k].we;
      write_addr = tbl[k].wa;
      write_data = tbl[k].wd;
      pc         = tbl[k].pc;
      set_ra(tbl[k].ra, tbl[k].ra, tbl[k].ra);
      settle();
      for (int i = 0; i < NR; i++) chk($sformatf("vec%0d_port%0d", k, i), pd(rd0, i), tbl[k].exp);
      cyc();
    end

    // Banking: r3 is private per bank, shared registers are visible everywhere.
    write_en = 1'b1; write_addr = 4'h3; write_data = 16'hABCD; cyc();
    irq_enter = 1'b1; cyc();
    set_ra(4'h3, 4'hC, 4'h9);
    settle();
    chk("enter_bank_ptr", {14'b0, bp0}, 16'd1);
    chk("bank1_r3", pd(rd0, 0), 16'h0000);
    chk("bank1_isr", pd(rd0, 1), 16'hBEEF);
    chk("bank1_scratch9", pd(rd0, 2), 16'h5A5A);
    write_en = 1'b1; write_addr = 4'h3; write_data = 16'h1234; cyc();
    irq_exit = 1'b1; cyc();
    set_ra(4'h3, 4'h0, 4'hB);
    settle();
    chk("exit_bank_ptr", {14'b0, bp0}, 16'd0);
    chk("bank0_r3_restored", pd(rd0, 0), 16'hABCD);
    chk("bank0_r0", pd(rd0, 1), 16'h0101);
    chk("bank0_scratchB", pd(rd0, 2), 16'h00BB);
    irq_enter = 1'b1; cyc();
    set_ra(4'h3, 4'h3, 4'h3);
    settle();
    chk("bank1_r3_persist", pd(rd0, 0), 16'h1234);
    chk("clr_bank1_r3_zeroed", pd(rd1, 0), 16'h0000);
    irq_exit = 1'b1; cyc();

    // Stack limits.
    for (int k = 0; k < 4; k++) begin
      irq_enter = 1'b1; cyc(); settle();
      chk($sformatf("push%0d_ptr", k), {14'b0, bp0}, {14'b0, up_bp[k]});
      chk($sformatf("push%0d_ovf", k), {15'b0, ovf0}, (k == 3) ? 16'd1 : 16'd0);
    end
    for (int k = 0; k < 4; k++) begin
      irq_exit = 1'b1; cyc(); settle();
      chk($sformatf("pop%0d_ptr", k), {14'b0, bp0}, {14'b0, dn_bp[k]});
      chk($sformatf("pop%0d_unf", k), {15'b0, unf0}, (k == 3) ? 16'd1 : 16'd0);
    end
    chk("ovf_sticky", {15'b0, ovf0}, 16'd1);

    // Clear on enter: same-cycle write lands in the old bank.
    irq_enter = 1'b1; cyc();
    write_en = 1'b1; write_addr = 4'h0; write_data = 16'h7777; cyc();
    irq_exit = 1'b1; cyc();
    irq_enter = 1'b1; write_en = 1'b1; write_addr = 4'h0; write_data = 16'h1111; cyc();
    set_ra(4'h0, 4'h0, 4'h0);
    settle();
    chk("clr_enter_ptr", {14'b0, bp1}, 16'd1);
    chk("clr_bank1_r0", pd(rd1, 0), 16'h0000);
    chk("keep_bank1_r0", pd(rd0, 0), 16'h7777);
    irq_exit = 1'b1; cyc();
    settle();
    chk("clr_bank0_r0", pd(rd1, 0), 16'h1111);
    chk("keep_bank0_r0", pd(rd0, 0), 16'h1111);

    // Failed push must not clear the top bank.
    for (int k = 0; k < 3; k++) begin irq_enter = 1'b1; cyc(); end
    write_en = 1'b1; write_addr = 4'h0; write_data = 16'h0333; cyc();
    irq_enter = 1'b1; cyc();
    settle();
    chk("clr_full_ptr", {14'b0, bp1}, 16'd3);
    chk("clr_full_r0_kept", pd(rd1, 0), 16'h0333);
    for (int k = 0; k < 3; k++) begin irq_exit = 1'b1; cyc(); end

    // Reset wins over a write and a push in the same cycle.
    reset = 1'b1; write_en = 1'b1; write_addr = 4'h0; write_data = 16'hDEAD; irq_enter = 1'b1;
    cyc();
    reset = 1'b0;
    set_ra(4'h0, 4'h9, 4'hC);
    settle();
    chk("rst_pri_ptr", {14'b0, bp0}, 16'd0);
    chk("rst_pri_ovf", {15'b0, ovf0}, 16'd0);
    chk("rst_pri_unf", {15'b0, unf0}, 16'd0);
    chk("rst_pri_r0", pd(rd0, 0), 16'h0000);
    chk("rst_pri_r9", pd(rd0, 1), 16'h0000);
    chk("rst_pri_isr", pd(rd0, 2), 16'h0000);

    // Enter and exit together: no move, no flag.
    irq_enter = 1'b1; irq_exit = 1'b1; cyc();
    settle();
    chk("both_ptr0", {14'b0, bp1}, 16'd0);
    chk("both_no_unf", {15'b0, unf1}, 16'd0);
    irq_enter = 1'b1; cyc();
    irq_enter = 1'b1; irq_exit = 1'b1; cyc();
    settle();
    chk("both_ptr1", {14'b0, bp1}, 16'd1);
    chk("both_no_ovf", {15'b0, ovf1}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
